// File: rtl/to8bit_pkg.sv
// Shared definitions for the 8-bit link: mode codes, serializer state encoding
// and the last-byte-index helper.
package to8bit_pkg;

    localparam logic [1:0] MODE8  = 2'b00;
    localparam logic [1:0] MODE16 = 2'b01;
    localparam logic [1:0] MODE32 = 2'b10;

    typedef enum logic [0:0] {
        StIdle,
        StSend
    } state_e;

    // Index of the final byte of a word in the given mode; 2'b11 falls back to 8-bit.
    function automatic logic [1:0] lastIdx(input logic [1:0] mode);
        case (mode)
            MODE16:  return 2'd1;
            MODE32:  return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/to8bit_ser_if.sv
// Word-in / byte-out bus of the serializer. The master side drives the word and
// the downstream ready; the slave side is the serializer itself.
interface to8bit_ser_if;

    logic [1:0]  data_s;
    logic [7:0]  data_in;
    logic [15:0] data_in16;
    logic [31:0] data_in32;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  data_out;
    logic        out_valid;
    logic        out_ready;
    logic        ph16;
    logic        ph32;

    modport master (
        output data_s, data_in, data_in16, data_in32, in_valid, out_ready,
        input  in_ready, data_out, out_valid, ph16, ph32
    );

    modport slave (
        input  data_s, data_in, data_in16, data_in32, in_valid, out_ready,
        output in_ready, data_out, out_valid, ph16, ph32
    );

endinterface

// File: rtl/to8bit_phase.sv
// Byte-index to phase-strobe decoder. Produces the clk16/clk32-style strobes the
// receiver expects for a given byte position; 8-bit words keep both strobes high.
module to8bit_phase
    import to8bit_pkg::*;
(
    input  logic [1:0] cnt_i,
    input  logic [1:0] mode_i,
    output logic       ph16_o,
    output logic       ph32_o
);

    // Strobes follow the byte index only for multi-byte modes.
    always_comb begin
        ph16_o = 1'b1;
        ph32_o = 1'b1;
        if (mode_i == MODE16 || mode_i == MODE32) begin
            ph16_o = ~cnt_i[0];
            ph32_o = ~cnt_i[1];
        end
    end

endmodule

// File: rtl/to8bit_ser.sv
// Word-to-byte serializer: takes one 8/16/32-bit word per handshake and emits it
// LSB-first as registered bytes with phase strobes for the from8bit receiver.
module to8bit_ser
    import to8bit_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         enb_i,
    to8bit_ser_if.slave  bus_io
);

    state_e      state_q, state_d;
    logic [31:0] word_q, word_d;
    logic [1:0]  mode_q, mode_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [1:0]  last_q, last_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        ph16_q, ph16_d;
    logic        ph32_q, ph32_d;

    logic        out_hs;
    logic        word_done;
    logic        in_ready;
    logic        accept;
    logic [31:0] sel_word;
    logic [31:0] byte_src;
    logic [1:0]  nxt_idx;
    logic [1:0]  nxt_mode;
    logic [7:0]  nxt_byte;
    logic        nxt_ph16;
    logic        nxt_ph32;

    // Handshakes only count while enabled, so enb_i=0 freezes progress.
    assign out_hs    = valid_q & bus_io.out_ready & enb_i;
    assign word_done = out_hs & (cnt_q == last_q);
    assign in_ready  = rst_ni & enb_i & ((state_q == StIdle) | word_done);
    assign accept    = bus_io.in_valid & in_ready;

    // Pick the input word for the requested mode, zero-extended to 32 bits.
    always_comb begin
        sel_word = {24'h0, bus_io.data_in};
        case (bus_io.data_s)
            MODE16:  sel_word = {16'h0, bus_io.data_in16};
            MODE32:  sel_word = bus_io.data_in32;
            default: sel_word = {24'h0, bus_io.data_in};
        endcase
    end

    // Byte position and mode for the byte about to be registered: byte 0 of the
    // incoming word on accept, otherwise the successor within the held word.
    always_comb begin
        nxt_idx  = accept ? 2'd0 : 2'(cnt_q + 2'd1);
        nxt_mode = accept ? bus_io.data_s : mode_q;
        byte_src = accept ? sel_word : word_q;
        nxt_byte = byte_src[7:0];
        case (nxt_idx)
            2'd1:    nxt_byte = byte_src[15:8];
            2'd2:    nxt_byte = byte_src[23:16];
            2'd3:    nxt_byte = byte_src[31:24];
            default: nxt_byte = byte_src[7:0];
        endcase
    end

    to8bit_phase u_phase (
        .cnt_i  (nxt_idx),
        .mode_i (nxt_mode),
        .ph16_o (nxt_ph16),
        .ph32_o (nxt_ph32)
    );

    // Next-state logic: load on accept, advance on a mid-word handshake, drop to
    // idle once the last byte is taken with no follow-on word.
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        data_d  = data_q;
        valid_d = valid_q;
        ph16_d  = ph16_q;
        ph32_d  = ph32_q;

        if (accept) begin
            state_d = StSend;
            word_d  = sel_word;
            mode_d  = bus_io.data_s;
            last_d  = lastIdx(bus_io.data_s);
            cnt_d   = 2'd0;
            data_d  = nxt_byte;
            valid_d = 1'b1;
            ph16_d  = nxt_ph16;
            ph32_d  = nxt_ph32;
        end else if (state_q == StSend && out_hs) begin
            if (cnt_q != last_q) begin
                cnt_d  = nxt_idx;
                data_d = nxt_byte;
                ph16_d = nxt_ph16;
                ph32_d = nxt_ph32;
            end else begin
                state_d = StIdle;
                valid_d = 1'b0;
            end
        end
    end

    // State register: synchronous active-low reset beats enable; enb_i=0 holds all.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            word_q  <= 32'h0;
            mode_q  <= MODE8;
            cnt_q   <= 2'd0;
            last_q  <= 2'd0;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            ph16_q  <= 1'b0;
            ph32_q  <= 1'b0;
        end else if (enb_i) begin
            state_q <= state_d;
            word_q  <= word_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ph16_q  <= ph16_d;
            ph32_q  <= ph32_d;
        end
    end

    assign bus_io.in_ready  = in_ready;
    assign bus_io.data_out  = data_q;
    assign bus_io.out_valid = valid_q;
    assign bus_io.ph16      = ph16_q;
    assign bus_io.ph32      = ph32_q;

endmodule

// File: tb/tb_to8bit_ser.sv
// Directed bench for the word-to-byte serializer.
module tb_to8bit_ser;

    logic clk;
    logic rst_n;
    logic enb;
    int   n_checks;
    int   n_fail;

    to8bit_ser_if bus ();

    to8bit_ser dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .enb_i  (enb),
        .bus_io (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        enb = 1'b1;
        bus.in_valid = 1'b1;
        bus.data_s = 2'b10;
        bus.data_in32 = 32'h11223344;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            n_checks++;
            if (bus.in_ready !== 1'b0) begin
                n_fail++; $display("FAIL rst_in_ready cyc %0d got %b exp 0", k, bus.in_ready);
            end
            n_checks++;
            if (bus.out_valid !== 1'b0) begin
                n_fail++; $display("FAIL rst_out_valid cyc %0d got %b exp 0", k, bus.out_valid);
            end
            n_checks++;
            if (bus.data_out !== 8'h00) begin
                n_fail++; $display("FAIL rst_data_out cyc %0d got %h exp 00", k, bus.data_out);
            end
            n_checks++;
            if ({bus.ph32, bus.ph16} !== 2'b00) begin
                n_fail++;
                $display("FAIL rst_phase cyc %0d got %b exp 00", k, {bus.ph32, bus.ph16});
            end
        end
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL idle_in_ready got %b exp 1", bus.in_ready);
        end
    endtask

    task automatic test_8bit();
        logic [7:0] words [2] = '{8'hA5, 8'h3C};
        bus.data_s = 2'b00;
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.data_in = words[i];
            #1;
            n_checks++;
            if (bus.in_ready !== 1'b1) begin
                n_fail++; $display("FAIL b8_in_ready word %0d got %b exp 1", i, bus.in_ready);
            end
            step();
            n_checks++;
            if (bus.data_out !== words[i] || bus.out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL b8_byte word %0d got %h/%b exp %h/1", i, bus.data_out,
                         bus.out_valid, words[i]);
            end
            n_checks++;
            if ({bus.ph32, bus.ph16} !== 2'b11) begin
                n_fail++;
                $display("FAIL b8_phase word %0d got %b exp 11", i, {bus.ph32, bus.ph16});
            end
        end
        bus.in_valid = 1'b0;
        step();
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL b8_drain got %b exp 0", bus.out_valid);
        end
    endtask

    task automatic test_16bit();
        logic [7:0]  exp_b  [2] = '{8'hEF, 8'hBE};
        logic [1:0]  exp_ph [2] = '{2'b11, 2'b10};
        logic [15:0] rx16;
        rx16 = 16'h0;
        bus.data_s = 2'b01;
        bus.data_in16 = 16'hBEEF;
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            n_checks++;
            if (bus.data_out !== exp_b[k] || bus.out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL b16_byte %0d got %h/%b exp %h/1", k, bus.data_out,
                         bus.out_valid, exp_b[k]);
            end
            n_checks++;
            if ({bus.ph32, bus.ph16} !== exp_ph[k]) begin
                n_fail++;
                $display("FAIL b16_phase %0d got %b exp %b", k, {bus.ph32, bus.ph16}, exp_ph[k]);
            end
            n_checks++;
            if (bus.in_ready !== (k == 1)) begin
                n_fail++; $display("FAIL b16_in_ready %0d got %b exp %b", k, bus.in_ready, k == 1);
            end
            // Receiver model: ph16 marks the low byte of a 16-bit word.
            if (bus.ph16) rx16[7:0] = bus.data_out;
            else rx16[15:8] = bus.data_out;
            step();
        end
        n_checks++;
        if (rx16 !== 16'hBEEF || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b16_rx got %h/%b exp BEEF/0", rx16, bus.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] words [2] = '{16'h1122, 16'h3344};
        bus.data_s = 2'b01;
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.data_in16 = words[0];
        step();
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (bus.data_out !== words[i][7:0] || bus.in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_lo word %0d got %h/%b exp %h/0", i, bus.data_out,
                         bus.in_ready, words[i][7:0]);
            end
            step();
            if (i == 0) bus.data_in16 = words[1];
            else bus.in_valid = 1'b0;
            #1;
            n_checks++;
            if (bus.data_out !== words[i][15:8] || bus.in_ready !== 1'b1
                || bus.out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_hi word %0d got %h/%b/%b exp %h/1/1", i, bus.data_out,
                         bus.in_ready, bus.out_valid, words[i][15:8]);
            end
            step();
        end
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL b2b_drain got %b exp 0", bus.out_valid);
        end
    endtask

    task automatic test_32bit_stall();
        logic [7:0] exp_b  [7] = '{8'hEF, 8'hBE, 8'hBE, 8'hBE, 8'hBE, 8'hAD, 8'hDE};
        logic [1:0] exp_ph [7] = '{2'b11, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b00};
        logic       rdy    [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic       exp_ir [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        bus.data_s = 2'b10;
        bus.data_in32 = 32'hDEADBEEF;
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        for (int k = 0; k < 7; k++) begin
            bus.out_ready = rdy[k];
            #1;
            n_checks++;
            if (bus.data_out !== exp_b[k] || bus.out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL b32_byte cyc %0d got %h/%b exp %h/1", k, bus.data_out,
                         bus.out_valid, exp_b[k]);
            end
            n_checks++;
            if ({bus.ph32, bus.ph16} !== exp_ph[k]) begin
                n_fail++;
                $display("FAIL b32_phase cyc %0d got %b exp %b", k, {bus.ph32, bus.ph16},
                         exp_ph[k]);
            end
            n_checks++;
            if (bus.in_ready !== exp_ir[k]) begin
                n_fail++;
                $display("FAIL b32_in_ready cyc %0d got %b exp %b", k, bus.in_ready, exp_ir[k]);
            end
            step();
        end
        bus.out_ready = 1'b1;
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL b32_drain got %b exp 0", bus.out_valid);
        end
    endtask

    task automatic test_mode_enb();
        logic [7:0] exp_b  [6] = '{8'h78, 8'h56, 8'h56, 8'h56, 8'h34, 8'h12};
        logic [1:0] exp_ph [6] = '{2'b11, 2'b10, 2'b10, 2'b10, 2'b01, 2'b00};
        logic       en     [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic       exp_ir [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        bus.data_s = 2'b10;
        bus.data_in32 = 32'h12345678;
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        bus.data_s = 2'b00;
        bus.data_in32 = 32'hFFFFFFFF;
        bus.data_in = 8'hFF;
        for (int k = 0; k < 6; k++) begin
            enb = en[k];
            #1;
            n_checks++;
            if (bus.data_out !== exp_b[k] || bus.out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL enb_byte cyc %0d got %h/%b exp %h/1", k, bus.data_out,
                         bus.out_valid, exp_b[k]);
            end
            n_checks++;
            if ({bus.ph32, bus.ph16} !== exp_ph[k] || bus.in_ready !== exp_ir[k]) begin
                n_fail++;
                $display("FAIL enb_ph_rdy cyc %0d got %b/%b exp %b/%b", k,
                         {bus.ph32, bus.ph16}, bus.in_ready, exp_ph[k], exp_ir[k]);
            end
            step();
        end
        enb = 1'b1;
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL enb_drain got %b exp 0", bus.out_valid);
        end
    endtask

    task automatic test_reset_mid();
        bus.data_s = 2'b10;
        bus.data_in32 = 32'hCAFEF00D;
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        n_checks++;
        if (bus.data_out !== 8'hFE || {bus.ph32, bus.ph16} !== 2'b01) begin
            n_fail++;
            $display("FAIL rmid_byte2 got %h/%b exp FE/01", bus.data_out, {bus.ph32, bus.ph16});
        end
        rst_n = 1'b0;
        step();
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.data_out !== 8'h00 || {bus.ph32, bus.ph16} !== 2'b00
            || bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_reset got %b/%h/%b/%b exp 0/00/00/0", bus.out_valid,
                     bus.data_out, {bus.ph32, bus.ph16}, bus.in_ready);
        end
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL rmid_idle got %b exp 1", bus.in_ready);
        end
        bus.data_s = 2'b01;
        bus.data_in16 = 16'h1234;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        n_checks++;
        if (bus.data_out !== 8'h34 || {bus.ph32, bus.ph16} !== 2'b11 || bus.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rmid_new0 got %h/%b/%b exp 34/11/1", bus.data_out,
                     {bus.ph32, bus.ph16}, bus.out_valid);
        end
        step();
        n_checks++;
        if (bus.data_out !== 8'h12 || {bus.ph32, bus.ph16} !== 2'b10) begin
            n_fail++;
            $display("FAIL rmid_new1 got %h/%b exp 12/10", bus.data_out, {bus.ph32, bus.ph16});
        end
        step();
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL rmid_drain got %b exp 0", bus.out_valid);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        rst_n = 1'b0;
        enb = 1'b1;
        bus.data_s = 2'b00;
        bus.data_in = 8'h00;
        bus.data_in16 = 16'h0;
        bus.data_in32 = 32'h0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_8bit();
        test_16bit();
        test_back_to_back();
        test_32bit_stall();
        test_mode_enb();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
